onchip_mem_arbiter: RTL and testbench

- Two-port Avalon-MM arbiter that shares the single-port 1024x32 on-chip RAM between two masters: port 0 is the Nios II data master and port 1 is the robot-control / video DMA engine.
- Round-robin grant, one command issued per cycle, read data returned with fixed 1-cycle latency on the requesting port.
- Sits between the interconnect and the RAM's s1 interface. Drives the RAM address, byteenable, chipselect, write, writedata and clken pins.

---
 rtl/onchip_mem_arbiter.sv | 133 +++++++++++++
 tb/tb_onchip_mem_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/onchip_mem_arbiter.sv
// Two-port round-robin arbiter sharing a single-port on-chip RAM between two Avalon-MM masters.
// Commands issue combinationally in the grant cycle; read data returns one cycle later on the requesting port.
module onchip_mem_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                reset_n,

  input  logic [ADDR_W-1:0]   p0_address,
  input  logic [DATA_W/8-1:0] p0_byteenable,
  input  logic                p0_read,
  input  logic                p0_write,
  input  logic [DATA_W-1:0]   p0_writedata,
  output logic                p0_waitrequest,
  output logic [DATA_W-1:0]   p0_readdata,
  output logic                p0_readdatavalid,

  input  logic [ADDR_W-1:0]   p1_address,
  input  logic [DATA_W/8-1:0] p1_byteenable,
  input  logic                p1_read,
  input  logic                p1_write,
  input  logic [DATA_W-1:0]   p1_writedata,
  output logic                p1_waitrequest,
  output logic [DATA_W-1:0]   p1_readdata,
  output logic                p1_readdatavalid,

  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata,

  input  logic                cnt_clear,
  output logic [CNT_W-1:0]    contention_count
);

  localparam int BE_W = DATA_W / 8;

  logic                req0, req1;
  logic                gnt0, gnt1;
  logic                wr_sel;

  logic                last_grant_q, last_grant_d;
  logic                rd_valid_q, rd_valid_d;
  logic                rd_port_q, rd_port_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  always_comb begin
    req0 = p0_read | p0_write;
    req1 = p1_read | p1_write;

    // Grants are suppressed while reset is asserted so waitrequest mirrors the request.
    gnt0 = reset_n & req0 & (~req1 | last_grant_q);
    gnt1 = reset_n & req1 & (~req0 | ~last_grant_q);

    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    wr_sel       = 1'b0;

    if (gnt0) begin
      last_grant_d = 1'b0;
      addr_d       = p0_address;
      be_d         = p0_byteenable;
      wdata_d      = p0_writedata;
      wr_sel       = p0_write;
    end else if (gnt1) begin
      last_grant_d = 1'b1;
      addr_d       = p1_address;
      be_d         = p1_byteenable;
      wdata_d      = p1_writedata;
      wr_sel       = p1_write;
    end

    // A port asserting read and write together is a write and gets no read response.
    rd_valid_d = (gnt0 | gnt1) & ~wr_sel;
    rd_port_d  = gnt1;

    if (cnt_clear) begin
      cnt_d = '0;
    end else if (req0 && req1 && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= 1'b1;
      rd_valid_q   <= 1'b0;
      rd_port_q    <= 1'b0;
      addr_q       <= '0;
      be_q         <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      rd_valid_q   <= rd_valid_d;
      rd_port_q    <= rd_port_d;
      addr_q       <= addr_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
    end
  end

  assign p0_waitrequest   = req0 & ~gnt0;
  assign p1_waitrequest   = req1 & ~gnt1;

  assign p0_readdata      = mem_readdata;
  assign p1_readdata      = mem_readdata;
  assign p0_readdatavalid = rd_valid_q & ~rd_port_q;
  assign p1_readdatavalid = rd_valid_q &  rd_port_q;

  assign mem_address      = addr_d;
  assign mem_byteenable   = be_d;
  assign mem_writedata    = wdata_d;
  assign mem_chipselect   = gnt0 | gnt1;
  assign mem_write        = wr_sel;
  assign mem_clken        = 1'b1;

  assign contention_count = cnt_q;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Directed bench for onchip_mem_arbiter with a behavioural 1024x32 RAM whose word i powers up as 0xA000_0000 | i.
module tb_onchip_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [9:0]  p0_address = '0, p1_address = '0;
  logic [3:0]  p0_byteenable = '0, p1_byteenable = '0;
  logic        p0_read = 1'b0, p0_write = 1'b0, p1_read = 1'b0, p1_write = 1'b0;
  logic [31:0] p0_writedata = '0, p1_writedata = '0;
  logic        p0_waitrequest, p1_waitrequest;
  logic [31:0] p0_readdata, p1_readdata;
  logic        p0_readdatavalid, p1_readdatavalid;
  logic [9:0]  mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata = '0;
  logic        cnt_clear = 1'b0;
  logic [15:0] contention_count;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] ram [0:1023];

  always #5 clk = ~clk;

  onchip_mem_arbiter #(.ADDR_W(10), .DATA_W(32), .CNT_W(16)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .p0_address       (p0_address),
    .p0_byteenable    (p0_byteenable),
    .p0_read          (p0_read),
    .p0_write         (p0_write),
    .p0_writedata     (p0_writedata),
    .p0_waitrequest   (p0_waitrequest),
    .p0_readdata      (p0_readdata),
    .p0_readdatavalid (p0_readdatavalid),
    .p1_address       (p1_address),
    .p1_byteenable    (p1_byteenable),
    .p1_read          (p1_read),
    .p1_write         (p1_write),
    .p1_writedata     (p1_writedata),
    .p1_waitrequest   (p1_waitrequest),
    .p1_readdata      (p1_readdata),
    .p1_readdatavalid (p1_readdatavalid),
    .mem_address      (mem_address),
    .mem_byteenable   (mem_byteenable),
    .mem_chipselect   (mem_chipselect),
    .mem_write        (mem_write),
    .mem_writedata    (mem_writedata),
    .mem_clken        (mem_clken),
    .mem_readdata     (mem_readdata),
    .cnt_clear        (cnt_clear),
    .contention_count (contention_count)
  );

  // Registered-address RAM: a read returns the pre-write contents of the addressed word.
  always @(posedge clk) begin
    if (mem_chipselect && mem_clken) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
      end else begin
        mem_readdata <= ram[mem_address];
      end
    end
  end

  task automatic idle_ports();
    p0_read = 1'b0; p0_write = 1'b0; p1_read = 1'b0; p1_write = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 1024; i++) ram[i] = 32'hA000_0000 | i;
    reset_n = 1'b0;
    p0_read = 1'b1; p0_address = 10'h123;
    @(negedge clk);
    vectors++;
    if (p0_waitrequest !== 1'b1 || mem_chipselect !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_wait: waitrequest=%b chipselect=%b, required 1/0", p0_waitrequest, mem_chipselect);
    end
    vectors++;
    if (mem_address !== 10'h0 || mem_write !== 1'b0 || mem_writedata !== 32'h0 || mem_byteenable !== 4'h0 ||
        contention_count !== 16'h0 || p0_readdatavalid !== 1'b0 || p1_readdatavalid !== 1'b0 || mem_clken !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_state: addr=%h wr=%b wd=%h be=%h cnt=%h rdv=%b%b clken=%b, required zeros and clken=1",
               mem_address, mem_write, mem_writedata, mem_byteenable, contention_count,
               p0_readdatavalid, p1_readdatavalid, mem_clken);
    end
    idle_ports();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_read();
    p0_read = 1'b1; p0_address = 10'h005;
    @(negedge clk);
    vectors++;
    if (p0_waitrequest !== 1'b0 || mem_chipselect !== 1'b1 || mem_address !== 10'h005) begin
      miscompares++;
      $display("FAIL single_issue: wait=%b cs=%b addr=%h, required 0/1/005", p0_waitrequest, mem_chipselect, mem_address);
    end
    @(posedge clk); #1;
    idle_ports();
    @(negedge clk);
    vectors++;
    if (p0_readdatavalid !== 1'b1 || p0_readdata !== 32'hA000_0005 || p1_readdatavalid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_return: rdv0=%b data=%h rdv1=%b, required 1/a0000005/0",
               p0_readdatavalid, p0_readdata, p1_readdatavalid);
    end
    @(posedge clk); #1;
    @(negedge clk);
    vectors++;
    if (p0_readdatavalid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_pulse: rdv0=%b one cycle later, required 0", p0_readdatavalid);
    end
  endtask

  task automatic test_round_robin();
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    p0_read = 1'b1; p0_address = 10'h010;
    p1_read = 1'b1; p1_address = 10'h020;
    for (int c = 0; c < 5; c++) begin
      if (c == 4) idle_ports();
      @(negedge clk);
      if (c < 4) begin
        vectors++;
        if (p0_waitrequest !== c[0] || p1_waitrequest !== !c[0]) begin
          miscompares++;
          $display("FAIL rr_grant c%0d: wait0=%b wait1=%b, required %b/%b", c, p0_waitrequest, p1_waitrequest, c[0], !c[0]);
        end
      end
      vectors++;
      if (contention_count !== 16'(c)) begin
        miscompares++;
        $display("FAIL rr_count c%0d: count=%0d, required %0d", c, contention_count, c);
      end
      if (c > 0) begin
        vectors++;
        if (c[0]) begin
          if (p0_readdatavalid !== 1'b1 || p1_readdatavalid !== 1'b0 || p0_readdata !== 32'hA000_0010) begin
            miscompares++;
            $display("FAIL rr_return c%0d: rdv=%b%b data=%h, required p0 a0000010", c, p0_readdatavalid, p1_readdatavalid, p0_readdata);
          end
        end else begin
          if (p1_readdatavalid !== 1'b1 || p0_readdatavalid !== 1'b0 || p1_readdata !== 32'hA000_0020) begin
            miscompares++;
            $display("FAIL rr_return c%0d: rdv=%b%b data=%h, required p1 a0000020", c, p0_readdatavalid, p1_readdatavalid, p1_readdata);
          end
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_partial_write();
    p1_write = 1'b1; p1_address = 10'h3FF; p1_byteenable = 4'b0011; p1_writedata = 32'hDEAD_BEEF;
    @(negedge clk);
    vectors++;
    if (p1_waitrequest !== 1'b0 || mem_write !== 1'b1 || mem_address !== 10'h3FF ||
        mem_byteenable !== 4'b0011 || mem_writedata !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL pw_issue: wait=%b wr=%b addr=%h be=%b wd=%h, required 0/1/3ff/0011/deadbeef",
               p1_waitrequest, mem_write, mem_address, mem_byteenable, mem_writedata);
    end
    @(posedge clk); #1;
    idle_ports();
    p0_read = 1'b1; p0_address = 10'h3FF;
    @(posedge clk); #1;
    idle_ports();
    @(negedge clk);
    vectors++;
    if (p0_readdatavalid !== 1'b1 || p0_readdata !== 32'hA000_BEEF || p1_readdatavalid !== 1'b0) begin
      miscompares++;
      $display("FAIL pw_readback: rdv0=%b data=%h rdv1=%b, required 1/a000beef/0", p0_readdatavalid, p0_readdata, p1_readdatavalid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    p0_read = 1'b1; p0_address = 10'h040;
    @(posedge clk); #1;
    idle_ports();
    p1_write = 1'b1; p1_address = 10'h040; p1_byteenable = 4'hF; p1_writedata = 32'h1234_5678;
    @(negedge clk);
    vectors++;
    if (p1_waitrequest !== 1'b0 || mem_write !== 1'b1 || p0_readdatavalid !== 1'b1 ||
        p0_readdata !== 32'hA000_0040 || p1_readdatavalid !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_old: wait1=%b wr=%b rdv0=%b data=%h rdv1=%b, required 0/1/1/a0000040/0",
               p1_waitrequest, mem_write, p0_readdatavalid, p0_readdata, p1_readdatavalid);
    end
    @(posedge clk); #1;
    idle_ports();
    p0_read = 1'b1; p0_address = 10'h040;
    @(posedge clk); #1;
    idle_ports();
    @(negedge clk);
    vectors++;
    if (p0_readdatavalid !== 1'b1 || p0_readdata !== 32'h1234_5678) begin
      miscompares++;
      $display("FAIL b2b_new: rdv0=%b data=%h, required 1/12345678", p0_readdatavalid, p0_readdata);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_boundaries();
    // Zero-byteenable write still takes a slot; read+write together is a write with no response.
    p0_write = 1'b1; p0_address = 10'h000; p0_byteenable = 4'h0; p0_writedata = 32'hFFFF_FFFF;
    @(negedge clk);
    vectors++;
    if (p0_waitrequest !== 1'b0 || mem_chipselect !== 1'b1 || mem_write !== 1'b1 || mem_address !== 10'h000) begin
      miscompares++;
      $display("FAIL be0_issue: wait=%b cs=%b wr=%b addr=%h, required 0/1/1/000", p0_waitrequest, mem_chipselect, mem_write, mem_address);
    end
    @(posedge clk); #1;
    p0_read = 1'b1; p0_write = 1'b1; p0_address = 10'h001; p0_byteenable = 4'hF; p0_writedata = 32'h0000_0055;
    @(negedge clk);
    vectors++;
    if (mem_write !== 1'b1 || mem_chipselect !== 1'b1) begin
      miscompares++;
      $display("FAIL rw_issue: wr=%b cs=%b, required 1/1", mem_write, mem_chipselect);
    end
    @(posedge clk); #1;
    idle_ports();
    p0_read = 1'b1; p0_address = 10'h000;
    @(negedge clk);
    vectors++;
    if (p0_readdatavalid !== 1'b0) begin
      miscompares++;
      $display("FAIL rw_noresp: rdv0=%b after read+write, required 0", p0_readdatavalid);
    end
    @(posedge clk); #1;
    p0_address = 10'h001;
    @(negedge clk);
    vectors++;
    if (p0_readdatavalid !== 1'b1 || p0_readdata !== 32'hA000_0000) begin
      miscompares++;
      $display("FAIL be0_data: rdv0=%b data=%h, required 1/a0000000", p0_readdatavalid, p0_readdata);
    end
    @(posedge clk); #1;
    idle_ports();
    @(negedge clk);
    vectors++;
    if (p0_readdatavalid !== 1'b1 || p0_readdata !== 32'h0000_0055) begin
      miscompares++;
      $display("FAIL rw_data: rdv0=%b data=%h, required 1/00000055", p0_readdatavalid, p0_readdata);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_saturation();
    p0_read = 1'b1; p0_address = 10'h100;
    p1_read = 1'b1; p1_address = 10'h200;
    repeat (70000) @(posedge clk);
    #1;
    @(negedge clk);
    vectors++;
    if (contention_count !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL sat_count: count=%h, required ffff", contention_count);
    end
    @(posedge clk); #1;
    cnt_clear = 1'b1;
    @(negedge clk);
    vectors++;
    if (contention_count !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL sat_hold: count=%h during clear cycle, required ffff", contention_count);
    end
    @(posedge clk); #1;
    cnt_clear = 1'b0;
    @(negedge clk);
    vectors++;
    if (contention_count !== 16'h0000) begin
      miscompares++;
      $display("FAIL sat_clear: count=%h, required 0000", contention_count);
    end
    @(posedge clk); #1;
    idle_ports();
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    p0_read = 1'b1; p0_address = 10'h005;
    @(posedge clk); #1;
    reset_n = 1'b0;
    p0_read = 1'b1; p1_read = 1'b1; p0_address = 10'h3AA; p1_address = 10'h155;
    @(negedge clk);
    vectors++;
    if (p0_readdatavalid !== 1'b0 || p1_readdatavalid !== 1'b0 || mem_chipselect !== 1'b0 || mem_write !== 1'b0 ||
        mem_address !== 10'h0 || mem_writedata !== 32'h0 || mem_byteenable !== 4'h0 ||
        p0_waitrequest !== 1'b1 || p1_waitrequest !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_reset: rdv=%b%b cs=%b wr=%b addr=%h wd=%h be=%h wait=%b%b, required zeros and wait 11",
               p0_readdatavalid, p1_readdatavalid, mem_chipselect, mem_write, mem_address, mem_writedata,
               mem_byteenable, p0_waitrequest, p1_waitrequest);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle_ports();
    p0_write = 1'b1; p1_write = 1'b1; p0_byteenable = 4'h0; p1_byteenable = 4'h0;
    @(negedge clk);
    vectors++;
    if (p0_waitrequest !== 1'b0 || p1_waitrequest !== 1'b1 || p0_readdatavalid !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_first: wait0=%b wait1=%b rdv0=%b, required 0/1/0", p0_waitrequest, p1_waitrequest, p0_readdatavalid);
    end
    @(posedge clk); #1;
    idle_ports();
    @(negedge clk);
    vectors++;
    if (p0_readdatavalid !== 1'b0 || p1_readdatavalid !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_nordv: rdv=%b%b after release, required 00", p0_readdatavalid, p1_readdatavalid);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_partial_write();
    test_back_to_back();
    test_boundaries();
    test_saturation();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
